store_aux_rmw: RTL and testbench

Store-side companion to the load extractor: performs `sw`/`sh`/`sb` into data memory. It is the write-direction counterpart of the load zero-extension path. Word stores are written directly. Halfword and byte stores do a read-modify-write: fetch the addressed word, replace the low lane with the register value, write back. The block sits between the control unit (start/done handshake) and the synchronous data memory port, with the same lane convention as loads (low 16 / low 8 bits).

---
 rtl/store_aux_rmw.sv | 115 +++++++++++
 tb/tb_store_aux_rmw.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_aux_rmw.sv
// Store path for sw/sh/sb: word stores write directly, halfword/byte stores
// read the addressed word, replace the low lane and write it back.
module store_aux_rmw #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  SScontroler,
  input  logic [31:0] address,
  input  logic [31:0] B_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [1:0]          size_q, size_n;
  logic [DATA_W-1:0]   b_q, b_n;
  logic [DATA_W-1:0]   rd_q, rd_n;
  logic [DATA_W-1:0]   addr_n;
  logic [DATA_W-1:0]   merged_c;

  // Next-state, request latching and lane merge; outputs are registered from these.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    size_n  = size_q;
    b_n     = b_q;
    rd_n    = rd_q;
    addr_n  = mem_addr;

    unique case (state)
      IDLE: begin
        if (start) begin
          addr_n = address;
          b_n    = B_in;
          size_n = SScontroler;
          if (SScontroler == SZ_WORD) begin
            state_n = WRITE;
          end else if (SScontroler == SZ_RSVD) begin
            state_n = DONE;
          end else begin
            state_n = READ;
            cnt_n   = CNT_W'(READ_LATENCY);
          end
        end
      end
      READ: begin
        if (cnt == CNT_W'(0)) begin
          rd_n    = mem_rdata;
          state_n = WRITE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WRITE: state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    unique case (size_n)
      SZ_HALF: merged_c = {rd_n[31:16], b_n[15:0]};
      SZ_BYTE: merged_c = {rd_n[31:8], b_n[7:0]};
      default: merged_c = b_n;
    endcase
  end

  // State, latched request and registered memory/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      size_q    <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      size_q    <= size_n;
      b_q       <= b_n;
      rd_q      <= rd_n;
      mem_addr  <= addr_n;
      mem_wr    <= (state_n == WRITE);
      mem_wdata <= (state_n == WRITE) ? merged_c : '0;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_store_aux_rmw.sv
// Bench for store_aux_rmw: two instances (READ_LATENCY 1 and 3), each with a
// latency-pipelined memory and a timeline model of the store transaction.
module tb_store_aux_rmw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s [2];
  logic        start_s [2];
  logic [1:0]  ss_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] b_s     [2];
  logic [31:0] rdata_s [2];
  logic [31:0] maddr_s [2];
  logic [31:0] wdata_s [2];
  logic        wr_s    [2];
  logic        busy_s  [2];
  logic        done_s  [2];

  int          errors = 0;
  int          checks = 0;
  int          writes [2];
  logic [31:0] last_wdata [2];
  logic [31:0] ram     [2][256];
  logic [31:0] ref_mem [2][256];
  bit          chk_en  [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [1:0] sz, input logic [31:0] b,
                                        input logic [31:0] rd);
    if (sz == 2'b10) return {rd[31:16], b[15:0]};
    if (sz == 2'b01) return {rd[31:8], b[7:0]};
    return b;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned RL = (g == 0) ? 1 : 3;
    logic [31:0] pipe [8];

    store_aux_rmw #(.READ_LATENCY(RL)) dut (
      .clk         (clk),
      .reset       (reset_s[g]),
      .start       (start_s[g]),
      .SScontroler (ss_s[g]),
      .address     (addr_s[g]),
      .B_in        (b_s[g]),
      .mem_rdata   (rdata_s[g]),
      .mem_addr    (maddr_s[g]),
      .mem_wr      (wr_s[g]),
      .mem_wdata   (wdata_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g])
    );

    assign rdata_s[g] = pipe[RL-1];

    // Synchronous memory: write on the edge, read data emerges RL edges later.
    always @(posedge clk) begin
      if (wr_s[g]) ram[g][maddr_s[g][7:0]] = wdata_s[g];
      pipe[0] <= ram[g][maddr_s[g][7:0]];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    // Transaction model: cycles since acceptance decide every output.
    bit          act = 1'b0;
    int          n = 0;
    logic [1:0]  m_sz = 2'b00;
    logic [31:0] m_addr = '0;
    logic [31:0] m_b = '0;
    bit          exp_busy = 1'b0;
    bit          exp_done = 1'b0;
    bit          exp_wr = 1'b0;
    logic [31:0] exp_wdata = '0;

    function automatic int total(input logic [1:0] s);
      if (s == 2'b00) return 2;
      if (s == 2'b11) return 1;
      return 3 + int'(RL);
    endfunction

    always @(posedge clk) begin
      if (exp_wr) ref_mem[g][m_addr[7:0]] = exp_wdata;
      if (reset_s[g]) begin
        act    = 1'b0;
        m_addr = '0;
      end else if (!act) begin
        if (start_s[g]) begin
          act    = 1'b1;
          n      = 1;
          m_sz   = ss_s[g];
          m_addr = addr_s[g];
          m_b    = b_s[g];
        end
      end else begin
        n++;
        if (n > total(m_sz)) act = 1'b0;
      end
      exp_busy  = act;
      exp_done  = act && (n == total(m_sz));
      exp_wr    = act && (m_sz != 2'b11) && (n == total(m_sz) - 1);
      exp_wdata = exp_wr ? merge(m_sz, m_b, ref_mem[g][m_addr[7:0]]) : '0;
    end

    // Per-cycle comparison against the model, plus write bookkeeping.
    always @(negedge clk) begin
      if (wr_s[g]) begin
        writes[g]++;
        last_wdata[g] = wdata_s[g];
      end
      if (chk_en[g]) begin
        check($sformatf("i%0d busy", g),  32'(busy_s[g]), 32'(exp_busy));
        check($sformatf("i%0d done", g),  32'(done_s[g]), 32'(exp_done));
        check($sformatf("i%0d wr", g),    32'(wr_s[g]),   32'(exp_wr));
        check($sformatf("i%0d wdata", g), wdata_s[g],     exp_wdata);
        check($sformatf("i%0d addr", g),  maddr_s[g],     m_addr);
      end
    end
  end

  task automatic preload(input int g, input logic [7:0] a, input logic [31:0] v);
    ram[g][a]     = v;
    ref_mem[g][a] = v;
  endtask

  // One store; lat = cycles from start-sample cycle to done (0 on timeout).
  // poke: re-assert start and scramble inputs during the following cycle.
  task automatic run(input int g, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] b, input bit poke, output int lat);
    writes[g] = 0;
    @(negedge clk);
    start_s[g] = 1'b1;
    ss_s[g]    = sz;
    addr_s[g]  = a;
    b_s[g]     = b;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (done_s[g]) lat = k;
      if (k == 1 && poke) begin
        b_s[g]    = 32'hFF;
        addr_s[g] = 32'h4C;
        ss_s[g]   = 2'b00;
      end else begin
        start_s[g] = 1'b0;
      end
    end
    start_s[g] = 1'b0;
  endtask

  initial begin
    int lat;
    for (int g = 0; g < 2; g++) begin
      reset_s[g] = 1'b1;
      start_s[g] = 1'b0;
      ss_s[g]    = 2'b00;
      addr_s[g]  = '0;
      b_s[g]     = '0;
      writes[g]  = 0;
      last_wdata[g] = '0;
      chk_en[g]  = 1'b0;
      for (int i = 0; i < 256; i++) begin
        ram[g][i]     = '0;
        ref_mem[g][i] = '0;
      end
    end
    repeat (3) @(negedge clk);
    chk_en[0] = 1'b1;
    chk_en[1] = 1'b1;
    check("rst mem_addr",  maddr_s[0], 32'h0);
    check("rst mem_wr",    32'(wr_s[0]), 32'h0);
    check("rst mem_wdata", wdata_s[0], 32'h0);
    check("rst busy",      32'(busy_s[0]), 32'h0);
    check("rst done",      32'(done_s[0]), 32'h0);
    reset_s[0] = 1'b0;
    reset_s[1] = 1'b0;

    // Word store
    run(0, 2'b00, 32'h40, 32'hDEADBEEF, 1'b0, lat);
    check("word latency", 32'(lat), 32'd2);
    check("word wdata",   last_wdata[0], 32'hDEADBEEF);
    check("word writes",  32'(writes[0]), 32'd1);
    check("word ram",     ram[0][8'h40], 32'hDEADBEEF);

    // Halfword RMW
    preload(0, 8'h44, 32'h11223344);
    run(0, 2'b10, 32'h44, 32'hAAAABBBB, 1'b0, lat);
    check("half latency", 32'(lat), 32'd4);
    check("half wdata",   last_wdata[0], 32'h1122BBBB);
    check("half ram",     ram[0][8'h44], 32'h1122BBBB);

    // Byte RMW with inputs changed and start re-asserted while reading
    preload(0, 8'h48, 32'h11223344);
    run(0, 2'b01, 32'h48, 32'h000000EE, 1'b1, lat);
    check("byte latency", 32'(lat), 32'd4);
    check("byte ram",     ram[0][8'h48], 32'h112233EE);
    check("byte writes",  32'(writes[0]), 32'd1);
    check("byte no stray", ram[0][8'h4C], 32'h0);

    // Reserved size: done next cycle, no write
    run(0, 2'b11, 32'h50, 32'h12345678, 1'b0, lat);
    check("rsvd latency", 32'(lat), 32'd1);
    check("rsvd writes",  32'(writes[0]), 32'd0);
    check("rsvd ram",     ram[0][8'h50], 32'h0);

    // Reset during the second READ cycle aborts the RMW
    preload(0, 8'h54, 32'hCAFEF00D);
    writes[0] = 0;
    @(negedge clk);
    start_s[0] = 1'b1; ss_s[0] = 2'b10; addr_s[0] = 32'h54; b_s[0] = 32'h00001111;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    reset_s[0] = 1'b1;
    @(negedge clk);
    reset_s[0] = 1'b0;
    check("abort busy",     32'(busy_s[0]), 32'h0);
    check("abort mem_addr", maddr_s[0], 32'h0);
    check("abort done",     32'(done_s[0]), 32'h0);
    check("abort writes",   32'(writes[0]), 32'd0);
    check("abort ram",      ram[0][8'h54], 32'hCAFEF00D);
    run(0, 2'b10, 32'h54, 32'h00001111, 1'b0, lat);
    check("restart latency", 32'(lat), 32'd4);
    check("restart ram",     ram[0][8'h54], 32'hCAFE1111);

    // Start together with reset is dropped
    writes[0] = 0;
    @(negedge clk);
    start_s[0] = 1'b1; reset_s[0] = 1'b1; ss_s[0] = 2'b00; addr_s[0] = 32'h58; b_s[0] = 32'h1;
    @(negedge clk);
    start_s[0] = 1'b0; reset_s[0] = 1'b0;
    check("start+reset busy", 32'(busy_s[0]), 32'h0);
    repeat (3) @(negedge clk);
    check("start+reset writes", 32'(writes[0]), 32'd0);

    // READ_LATENCY = 3 instance
    preload(1, 8'h60, 32'hA1B2C3D4);
    run(1, 2'b01, 32'h60, 32'h0000005A, 1'b0, lat);
    check("rl3 byte latency", 32'(lat), 32'd6);
    check("rl3 byte wdata",   last_wdata[1], 32'hA1B2C35A);
    check("rl3 byte ram",     ram[1][8'h60], 32'hA1B2C35A);
    preload(1, 8'h64, 32'h01020304);
    run(1, 2'b10, 32'h64, 32'hFFFF9999, 1'b0, lat);
    check("rl3 half latency", 32'(lat), 32'd6);
    check("rl3 half ram",     ram[1][8'h64], 32'h01029999);
    run(1, 2'b00, 32'h68, 32'h5A5A0F0F, 1'b0, lat);
    check("rl3 word latency", 32'(lat), 32'd2);
    check("rl3 word ram",     ram[1][8'h68], 32'h5A5A0F0F);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
